// File: rtl/snitch_clkdiv2_ctrl_pkg.sv
// Shared types for the snitch_clkdiv2 mode controller.
//   clkdiv_ctrl_state_e : controller FSM states
//   holds_quiesce()     : states in which downstream must stay stalled
package snitch_clkdiv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SETTLE  = 3'd2,
    ALIGN   = 3'd3,
    SWITCH  = 3'd4,
    RELEASE = 3'd5,
    ABORT   = 3'd6,
    DONE    = 3'd7
  } clkdiv_ctrl_state_e;

  // Downstream is held stalled from the first quiesce request up to and
  // including the switch cycle itself.
  function automatic logic holds_quiesce(clkdiv_ctrl_state_e s);
    return s inside {QUIESCE, SETTLE, ALIGN, SWITCH};
  endfunction

endpackage

// File: rtl/snitch_clkdiv2_ctrl_if.sv
// Request / quiesce handshake bundle of the clkdiv2 mode controller.
//   req_valid/req_bypass/req_ready : mode change request (valid & ready)
//   done/err                       : completion pulse, err marks a timeout abort
//   quiesce_req/quiesce_ack        : drain request to downstream, level ack back
// slave  : the controller side
// master : requester and downstream logic (the controller's environment)
interface snitch_clkdiv2_ctrl_if;
  logic req_valid;
  logic req_bypass;
  logic req_ready;
  logic done;
  logic err;
  logic quiesce_req;
  logic quiesce_ack;

  modport slave (
    input  req_valid, req_bypass, quiesce_ack,
    output req_ready, done, err, quiesce_req
  );

  modport master (
    output req_valid, req_bypass, quiesce_ack,
    input  req_ready, done, err, quiesce_req
  );
endinterface

// File: rtl/snitch_clkdiv2_ctrl.sv
// Mode controller sitting directly upstream of snitch_clkdiv2, driving its
// bypass_i. Runs on the fast clock. A mode change is only applied after the
// downstream logic has acknowledged quiescence for SettleCycles cycles and
// only on the edge where the divider flop goes 1->0, so the output clock
// never gets a runt pulse. A quiesce that never completes aborts after
// TimeoutCycles and is reported via err_o / err_sticky_o.
//
// Ports
//   clk_i        fast clock (same net as divider clk_i)
//   rst_ni       asynchronous active-low reset (same as divider)
//   bus          request + quiesce handshake (slave side)
//   err_clear_i  clears err_sticky_o (a timeout in the same cycle wins)
//   err_sticky_o sticky timeout flag
//   bypass_o     to snitch_clkdiv2 bypass_i (1 = bypass, 0 = divide)
//   busy_o       FSM not in IDLE
module snitch_clkdiv2_ctrl
  import snitch_clkdiv_pkg::*;
#(
  parameter logic        BypassRst     = 1'b0,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  snitch_clkdiv2_ctrl_if.slave        bus,
  input  logic                        err_clear_i,
  output logic                        err_sticky_o,
  output logic                        bypass_o,
  output logic                        busy_o
);

  // One counter serves both the quiesce timeout and the settle window; it is
  // sized for the timeout, so SettleCycles must not exceed TimeoutCycles.
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t TimeoutMax = cnt_t'(TimeoutCycles - 1);
  localparam cnt_t SettleMax  = cnt_t'(SettleCycles - 1);

  clkdiv_ctrl_state_e state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic               phase_q;
  logic               req_q, req_d;
  logic               bypass_q, bypass_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               quiesce_q, quiesce_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  // Next-state logic. Registered outputs are derived from the next state so
  // that every output is a plain flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    bypass_d = bypass_q;
    sticky_d = sticky_q & ~err_clear_i;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d = bus.req_bypass;
          if (bus.req_bypass == bypass_q) begin
            state_d = DONE;
          end else begin
            state_d = QUIESCE;
            cnt_d   = '0;
          end
        end
      end

      QUIESCE: begin
        if (bus.quiesce_ack) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutMax) begin
          state_d = ABORT;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
        end
      end

      SETTLE: begin
        if (!bus.quiesce_ack) begin
          // Ack must be stable for the whole window; restart the timeout.
          state_d = QUIESCE;
          cnt_d   = '0;
        end else if (cnt_q == SettleMax) begin
          // phase_q==1 means the divider flop falls on this edge: switch now,
          // otherwise burn one cycle in ALIGN.
          if (phase_q) begin
            state_d  = SWITCH;
            bypass_d = req_q;
          end else begin
            state_d = ALIGN;
          end
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
        end
      end

      ALIGN: begin
        if (phase_q) begin
          state_d  = SWITCH;
          bypass_d = req_q;
        end
      end

      SWITCH:  state_d = RELEASE;

      RELEASE: begin
        if (!bus.quiesce_ack) state_d = DONE;
      end

      ABORT: begin
        sticky_d = 1'b1;
        err_d    = 1'b1;
        state_d  = DONE;
      end

      DONE:    state_d = IDLE;

      default: state_d = IDLE;
    endcase

    done_d    = (state_d == DONE);
    quiesce_d = holds_quiesce(state_d);
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      req_q     <= BypassRst;
      bypass_q  <= BypassRst;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      quiesce_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Mirror of the divider flop: free-running, never stalled.
      phase_q   <= ~phase_q;
      req_q     <= req_d;
      bypass_q  <= bypass_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      err_q     <= err_d;
      quiesce_q <= quiesce_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.quiesce_req = quiesce_q;
  assign err_sticky_o    = sticky_q;
  assign bypass_o        = bypass_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_snitch_clkdiv2_ctrl.sv
module tb_snitch_clkdiv2_ctrl;
  localparam int S = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic err_clear_i = 1'b0;
  logic err_sticky_o, bypass_o, busy_o;

  snitch_clkdiv2_ctrl_if ifc();

  snitch_clkdiv2_ctrl #(
    .BypassRst(1'b0), .SettleCycles(S), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(ifc), .err_clear_i(err_clear_i),
    .err_sticky_o(err_sticky_o), .bypass_o(bypass_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc;      // cycles since reset release; phase in cycle c is c%2
  int checks;
  int errors;
  bit m_bypass; // model: current mode
  bit m_sticky; // model: sticky error flag
  bit ackw [64]; // ack level for cycle accept+1+i

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(bit busy, bit dn, bit er, bit q, bit byp);
    chk("phase",   dut.phase_q,     cyc[0]);
    chk("ready",   ifc.req_ready,   ~busy);
    chk("busy",    busy_o,          busy);
    chk("done",    ifc.done,        dn);
    chk("err",     ifc.err,         er);
    chk("quiesce", ifc.quiesce_req, q);
    chk("bypass",  bypass_o,        byp);
    chk("sticky",  err_sticky_o,    m_sticky);
  endtask

  function automatic bit ack_at(int i);
    if (i < 0) return 1'b0;
    if (i >= 64) return 1'b1;
    return ackw[i];
  endfunction

  // Timing rules: quiesce wait lasts at most T cycles from its start; once
  // ack is seen it must stay high for the next S cycles, otherwise the wait
  // restarts the cycle after the drop. The switch lands on the first edge
  // after the settle window whose phase is 1. ev = switch cycle or abort cycle.
  task automatic predict(input int n, output bit ab, output int ev);
    int start;
    int q;
    int x;
    start = n + 1;
    ab = 1'b0;
    ev = 0;
    for (int it = 0; it < 16; it++) begin
      q = -1;
      x = -1;
      for (int c = start; c < start + T; c++)
        if (q < 0 && ack_at(c - n - 1)) q = c;
      if (q < 0) begin
        ab = 1'b1;
        ev = start + T;
        return;
      end
      for (int c = q + 1; c <= q + S; c++)
        if (x < 0 && !ack_at(c - n - 1)) x = c;
      if (x < 0) begin
        ev = q + S + 1 + ((((q + S) % 2) == 0) ? 1 : 0);
        return;
      end
      start = x + 1;
    end
  endtask

  // ack: low d cycles, high h cycles, low g cycles, then high; after the
  // switch ack is held k more cycles and then dropped.
  task automatic run_req(bit mode, int d, int h, int g, int k, bit clr_at_ev);
    bit trivial, ab, old, a, clr;
    int n, ev, dn;
    for (int i = 0; i < 64; i++)
      ackw[i] = (i >= d) && !((i >= d + h) && (i < d + h + g));
    n = cyc;
    old = m_bypass;
    trivial = (mode == m_bypass);
    ab = 1'b0;
    ev = 0;
    if (!trivial) predict(n, ab, ev);
    dn = trivial ? n + 1 : (ab ? ev + 1 : ev + k + 2);
    ifc.req_valid = 1'b1;
    ifc.req_bypass = mode;
    ifc.quiesce_ack = 1'b0;
    err_clear_i = 1'b0;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, old);
    tick();
    ifc.req_valid = 1'b0;
    ifc.req_bypass = ~mode; // must be ignored until done
    for (int c = n + 1; c <= dn + 1; c++) begin
      if (trivial) a = 1'b0;
      else if (ab) a = (c < ev) && ack_at(c - n - 1);
      else a = (c <= ev) ? ack_at(c - n - 1) : (c <= ev + k);
      clr = (c <= dn) && (clr_at_ev ? (ab && c == ev) : ($urandom_range(0, 7) == 0));
      ifc.quiesce_ack = a;
      err_clear_i = clr;
      chk_all(c <= dn, c == dn, ab && c == dn,
              !trivial && (ab ? (c < ev) : (c <= ev)),
              (!trivial && !ab && c >= ev) ? mode : old);
      if (ab && c == ev) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
      if (c <= dn) tick();
    end
    if (!trivial && !ab) m_bypass = mode;
    err_clear_i = 1'b0;
  endtask

  task automatic idle(int n, bit clr);
    for (int i = 0; i < n; i++) begin
      err_clear_i = clr;
      ifc.quiesce_ack = 1'b0;
      chk_all(1'b0, 1'b0, 1'b0, 1'b0, m_bypass);
      if (clr) m_sticky = 1'b0;
      tick();
    end
    err_clear_i = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    m_bypass = 1'b0;
    m_sticky = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_bypass = 1'b0;
    ifc.quiesce_ack = 1'b0;

    // reset values, then idle phase toggling
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    cyc = 0;
    idle(8, 1'b0);

    run_req(1'b0, 0, 64, 0, 0, 1'b0);   // trivial: already divided
    run_req(1'b1, 40, 1, 0, 0, 1'b1);   // timeout abort, clear collides with set
    idle(1, 1'b1);                       // clear the sticky flag
    idle(2, 1'b0);
    run_req(1'b1, 0, 64, 0, 2, 1'b0);   // ack already high
    run_req(1'b0, 1, 2, 2, 1, 1'b0);    // ack drops during settle
    run_req(1'b1, T - 1, 64, 0, 0, 1'b0); // ack in last quiesce cycle
    run_req(1'b0, T, 64, 0, 0, 1'b0);     // ack one cycle too late
    run_req(1'b1, 2, 64, 0, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_req(1'($urandom_range(0, 1)), int'($urandom_range(0, T + 1)),
              int'($urandom_range(1, S + 2)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      idle(int'($urandom_range(0, 2)), 1'b0);
    end

    // reset while waiting in ALIGN: accept in an odd cycle so the settle
    // window ends on phase 0
    run_req(1'b1, 0, 64, 0, 1, 1'b0);
    if ((cyc % 2) == 0) idle(1, 1'b0);
    n = cyc;
    ifc.req_valid = 1'b1;
    ifc.req_bypass = 1'b0;
    ifc.quiesce_ack = 1'b1;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    ifc.req_valid = 1'b0;
    for (int c = n + 1; c <= n + 6; c++) begin
      chk_all(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      if (c < n + 6) tick();
    end
    rst_ni = 1'b0;
    #1;
    cyc = 0;
    m_bypass = 1'b0;
    m_sticky = 1'b0;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.quiesce_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_done", ifc.done, 1'b0);
      chk("rst_bypass", bypass_o, 1'b0);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    cyc = 0;
    idle(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
